// File: rtl/axil_pkg.sv
// AXI4-Lite master bridge shared types.
// Response codes, FSM states, protection default.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_SEND = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

  localparam logic [2:0] AXIL_PROT_DEFAULT = 3'b000;

  // SLVERR and DECERR both have bit 1 set.
  function automatic logic resp_is_err(
    input logic [1:0] resp
  );
    return resp[1];
  endfunction

endpackage

// File: rtl/axil_master_bridge.sv
// Core MMIO request to AXI4-Lite master bridge.
// Independent read/write channels, one outstanding each.
module axil_master_bridge
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    AXIL_START_WRITE,
  input  logic                    AXIL_START_READ,
  input  logic [ADDR_WIDTH-1:0]   AXIL_TRANSACTION_WRADDR,
  input  logic [DATA_WIDTH-1:0]   AXIL_TRANSACTION_WRDATA,
  input  logic [DATA_WIDTH/8-1:0] AXIL_TRANSACTION_WSTRB,
  input  logic [ADDR_WIDTH-1:0]   AXIL_TRANSACTION_RADDR,
  output logic [DATA_WIDTH-1:0]   AXIL_TRANSACTION_RDATA,
  output logic                    AXIL_DONE_WRITE,
  output logic                    AXIL_DONE_READ,
  output logic                    AXIL_BUSY_WRITE,
  output logic                    AXIL_BUSY_READ,
  output logic                    AXIL_ERR_WRITE,
  output logic                    AXIL_ERR_READ,
  output logic [ADDR_WIDTH-1:0]   M_AWADDR,
  output logic [2:0]              M_AWPROT,
  output logic                    M_AWVALID,
  input  logic                    M_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_WSTRB,
  output logic                    M_WVALID,
  input  logic                    M_WREADY,
  input  logic [1:0]              M_BRESP,
  input  logic                    M_BVALID,
  output logic                    M_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_ARADDR,
  output logic [2:0]              M_ARPROT,
  output logic                    M_ARVALID,
  input  logic                    M_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_RDATA,
  input  logic [1:0]              M_RRESP,
  input  logic                    M_RVALID,
  output logic                    M_RREADY
);

  wr_state_e                r_wstate;
  logic [ADDR_WIDTH-1:0]    r_awaddr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [DATA_WIDTH/8-1:0]  r_wstrb;
  logic                     r_awvalid;
  logic                     r_wvalid;
  logic                     r_bready;
  logic                     r_done_w;
  logic                     r_err_w;
  logic                     r_busy_w;

  rd_state_e                r_rstate;
  logic [ADDR_WIDTH-1:0]    r_araddr;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic                     r_arvalid;
  logic                     r_rready;
  logic                     r_done_r;
  logic                     r_err_r;
  logic                     r_busy_r;

  logic                     w_aw_pend;
  logic                     w_w_pend;

  // AW and W retire independently; a channel stays
  // pending only while valid and not yet accepted.
  assign w_aw_pend = r_awvalid & ~M_AWREADY;
  assign w_w_pend  = r_wvalid & ~M_WREADY;

  // Write channel FSM: address+data, then response.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wstate  <= W_IDLE;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_done_w  <= 1'b0;
      r_err_w   <= 1'b0;
      r_busy_w  <= 1'b0;
    end else begin
      r_done_w <= 1'b0;
      r_err_w  <= 1'b0;
      unique case (r_wstate)
        W_IDLE: begin
          if (AXIL_START_WRITE) begin
            r_awaddr  <= AXIL_TRANSACTION_WRADDR;
            r_wdata   <= AXIL_TRANSACTION_WRDATA;
            r_wstrb   <= AXIL_TRANSACTION_WSTRB;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_busy_w  <= 1'b1;
            r_wstate  <= W_SEND;
          end
        end
        W_SEND: begin
          if (r_awvalid && M_AWREADY)
            r_awvalid <= 1'b0;
          if (r_wvalid && M_WREADY)
            r_wvalid <= 1'b0;
          if (!w_aw_pend && !w_w_pend) begin
            r_bready <= 1'b1;
            r_wstate <= W_RESP;
          end
        end
        W_RESP: begin
          if (M_BVALID) begin
            r_bready <= 1'b0;
            r_done_w <= 1'b1;
            r_err_w  <= resp_is_err(M_BRESP);
            r_busy_w <= 1'b0;
            r_wstate <= W_IDLE;
          end
        end
        default: begin
          r_wstate <= W_IDLE;
        end
      endcase
    end
  end

  // Read channel FSM: address, then data capture.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rstate  <= R_IDLE;
      r_araddr  <= '0;
      r_rdata   <= '0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_done_r  <= 1'b0;
      r_err_r   <= 1'b0;
      r_busy_r  <= 1'b0;
    end else begin
      r_done_r <= 1'b0;
      r_err_r  <= 1'b0;
      unique case (r_rstate)
        R_IDLE: begin
          if (AXIL_START_READ) begin
            r_araddr  <= AXIL_TRANSACTION_RADDR;
            r_arvalid <= 1'b1;
            r_busy_r  <= 1'b1;
            r_rstate  <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (M_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (M_RVALID) begin
            r_rdata  <= M_RDATA;
            r_rready <= 1'b0;
            r_done_r <= 1'b1;
            r_err_r  <= resp_is_err(M_RRESP);
            r_busy_r <= 1'b0;
            r_rstate <= R_IDLE;
          end
        end
        default: begin
          r_rstate <= R_IDLE;
        end
      endcase
    end
  end

  assign M_AWADDR  = r_awaddr;
  assign M_AWPROT  = AXIL_PROT_DEFAULT;
  assign M_AWVALID = r_awvalid;
  assign M_WDATA   = r_wdata;
  assign M_WSTRB   = r_wstrb;
  assign M_WVALID  = r_wvalid;
  assign M_BREADY  = r_bready;
  assign M_ARADDR  = r_araddr;
  assign M_ARPROT  = AXIL_PROT_DEFAULT;
  assign M_ARVALID = r_arvalid;
  assign M_RREADY  = r_rready;

  assign AXIL_TRANSACTION_RDATA = r_rdata;
  assign AXIL_DONE_WRITE = r_done_w;
  assign AXIL_DONE_READ  = r_done_r;
  assign AXIL_BUSY_WRITE = r_busy_w;
  assign AXIL_BUSY_READ  = r_busy_r;
  assign AXIL_ERR_WRITE  = r_err_w;
  assign AXIL_ERR_READ   = r_err_r;

endmodule
